pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Sequences the iCE40 SB_PLL40_CORE wrapper: pulses the PLL's RESETB, waits for lock with a timeout, and requires lock to hold stable before releasing system reset.
- Retries a bounded number of times, then latches a failure flag.
- Runs in the 16 MHz reference clock domain, between the board clock pin and the pixel/system logic fed by the 200 MHz PLL output.
- `sys_reset` is consumed by per-domain reset synchronizers downstream.

Parameters:
- PLL_RESET_CYCLES, 16, cycles `pll_resetb` is held low per attempt (>=1).
- LOCK_TIMEOUT_CYCLES, 16000, cycles allowed in WAIT_LOCK before an attempt fails (1 ms at 16 MHz).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1).
- MAX_RETRIES, 3, re-attempts after the first before FAIL (>=0).
- RETRY_W, 2, width of `retry_count`; must hold MAX_RETRIES.

Ports:
- clock_in  input  1  16 MHz reference clock (same net as the PLL REFERENCECLK).
- reset  input  1  synchronous, active-high.
- locked  input  1  PLL LOCK, asynchronous to clock_in.
- restart  input  1  single-cycle request to restart sequencing.
- pll_resetb  output  1  to PLL RESETB, active-low.
- sys_reset  output  1  active-high reset for downstream logic.
- ready  output  1  high only in RUN.
- fail  output  1  high only in FAIL.
- retry_count  output  RETRY_W  retries consumed in the current sequence.
- lock_loss_count  output  8  saturating count of lock losses seen in RUN.

Behaviour:
- Clock and reset: one clock, `clock_in`; `reset` is synchronous and active-high. `reset` has priority over `restart`.
- Reset values: `pll_resetb`=0, `sys_reset`=1, `ready`=0, `fail`=0, `retry_count`=0, `lock_loss_count`=0, sync flops=0, state=RESET_PLL, counter=0.
- Lock synchronization: `locked` passes through a 2-flop synchronizer to give `locked_s`, so there are 2 cycles of latency. All decisions use `locked_s` only.
- Registered outputs: all outputs are registered, decoded from the next state, and change on the same edge as the state transition.
- Counter: one shared counter, width `$clog2` of the largest cycle parameter. It clears on every state change and counts up otherwise.
- RESET_PLL:
  - `pll_resetb`=0, `sys_reset`=1.
  - At counter==PLL_RESET_CYCLES-1, go to WAIT_LOCK. `pll_resetb` is therefore low for exactly PLL_RESET_CYCLES cycles.
- WAIT_LOCK:
  - `pll_resetb`=1, `sys_reset`=1.
  - If `locked_s`=1, go to STABILIZE.
  - Else, at counter==LOCK_TIMEOUT_CYCLES-1: if `retry_count`<MAX_RETRIES, increment `retry_count` and go to RESET_PLL; otherwise go to FAIL.
- STABILIZE:
  - `pll_resetb`=1, `sys_reset`=1.
  - If `locked_s`=0, go to WAIT_LOCK; the timeout restarts from 0 and `retry_count` is unchanged.
  - At counter==LOCK_STABLE_CYCLES-1 with `locked_s`=1, go to RUN.
- RUN:
  - `pll_resetb`=1, `sys_reset`=0, `ready`=1.
  - If `locked_s`=0: `lock_loss_count` increments (saturates at 255), `retry_count` clears, go to WAIT_LOCK. `sys_reset` reasserts on that edge.
- FAIL:
  - `pll_resetb`=0 (PLL held in reset), `sys_reset`=1, `fail`=1.
  - Terminal until `restart` or `reset`.
- restart:
  - Accepted in any state.
  - Next state RESET_PLL, counter=0, `retry_count`=0, `fail`=0. `lock_loss_count` is preserved.
  - `restart` beats every other transition in the same cycle.
- Glitch handling: `ready` and `sys_reset` never toggle mid-STABILIZE; a single-cycle `locked_s` drop restarts qualification.
- Simultaneous events in WAIT_LOCK: `locked_s` rising on the timeout cycle takes STABILIZE (lock wins over timeout).

Decomposition:
- Package `pll_seq_pkg`:
  - state enum RESET_PLL/WAIT_LOCK/STABILIZE/RUN/FAIL, 3-bit encoding.
  - a localparam function for counter width.
- Sub-module `sync_2ff`: reusable 2-flop synchronizer, synchronous active-high reset to 0. Used for `locked`.

Test Plan:
All scenarios use PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: `locked` tied 1, release `reset` -> `pll_resetb` low exactly 4 cycles, then `ready`=1 and `sys_reset`=0 exactly 13 cycles after `reset` deasserts (4 RESET_PLL + 1 WAIT_LOCK + 8 STABILIZE); `retry_count`=0.
- No lock: `locked` tied 0 -> 3 RESET_PLL pulses of 4 cycles each, spaced 24 cycles apart. `fail`=1 at cycle 72, `retry_count`=2, `pll_resetb` stays 0, `ready` is never 1.
- Glitch during qualification: `locked` drops 1 cycle at STABILIZE counter=5 -> back to WAIT_LOCK then STABILIZE again. `ready` rises 8 full stable cycles later, `sys_reset` is glitch-free, `retry_count`=0.
- Lock loss in RUN: drop `locked` -> `ready`=0 and `sys_reset`=1 exactly 3 cycles later (2 sync + 1 register). `lock_loss_count`=1, `pll_resetb` stays 1. Re-lock gives `ready` again after 8 stable cycles.
- Restart from FAIL: from the no-lock scenario, set `locked`=1 and pulse `restart` -> `fail`=0, `retry_count`=0, `pll_resetb` low 4 cycles, `ready` 13 cycles after `restart`.
- Reset mid-sequence: assert `reset` in STABILIZE at counter=3 with `lock_loss_count`=5 -> next edge, all outputs at reset values and `lock_loss_count`=0. With `restart` and `reset` high together, the reset values win.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

    // Width of the shared phase counter: enough bits to reach the longest phase.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Capture the asynchronous level, then re-register it to settle metastability.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives PLL RESETB, qualifies lock with timeout/retry, and gates system reset.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 16000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int RETRY_W             = 2
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               locked,
    input  logic               restart,
    output logic               pll_resetb,
    output logic               sys_reset,
    output logic               ready,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_count,
    output logic [7:0]         lock_loss_count
);

    localparam int CNT_W = cnt_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    pll_state_e         state_r;
    pll_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic [RETRY_W-1:0] retry_nxt_s;
    logic [7:0]         loss_nxt_s;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk   (clock_in),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    // Next-state, retry and lock-loss bookkeeping; restart overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_count;
        loss_nxt_s  = lock_loss_count;
        if (restart) begin
            state_nxt_s = RESET_PLL;
            retry_nxt_s = {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt_s = WAIT_LOCK;
                    end else begin
                        state_nxt_s = RESET_PLL;
                    end
                end
                WAIT_LOCK: begin
                    // Lock seen on the timeout cycle still counts as lock.
                    if (locked_s) begin
                        state_nxt_s = STABILIZE;
                    end else if (cnt_r == TMO_LAST) begin
                        if (retry_count < RETRY_MAX) begin
                            retry_nxt_s = retry_count + RETRY_W'(1);
                            state_nxt_s = RESET_PLL;
                        end else begin
                            state_nxt_s = FAIL;
                        end
                    end else begin
                        state_nxt_s = WAIT_LOCK;
                    end
                end
                STABILIZE: begin
                    if (!locked_s) begin
                        state_nxt_s = WAIT_LOCK;
                    end else if (cnt_r == STB_LAST) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = STABILIZE;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt_s = WAIT_LOCK;
                        retry_nxt_s = {RETRY_W{1'b0}};
                        if (lock_loss_count != 8'hFF) begin
                            loss_nxt_s = lock_loss_count + 8'd1;
                        end else begin
                            loss_nxt_s = lock_loss_count;
                        end
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                FAIL: begin
                    state_nxt_s = FAIL;
                end
                default: begin
                    state_nxt_s = RESET_PLL;
                    retry_nxt_s = {RETRY_W{1'b0}};
                end
            endcase
        end

        if (restart || (state_nxt_s != state_r)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // State, counter and outputs registered together; outputs decode the next state.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_r         <= RESET_PLL;
            cnt_r           <= {CNT_W{1'b0}};
            retry_count     <= {RETRY_W{1'b0}};
            lock_loss_count <= 8'd0;
            pll_resetb      <= 1'b0;
            sys_reset       <= 1'b1;
            ready           <= 1'b0;
            fail            <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            retry_count     <= retry_nxt_s;
            lock_loss_count <= loss_nxt_s;
            pll_resetb      <= !((state_nxt_s == RESET_PLL) || (state_nxt_s == FAIL));
            sys_reset       <= (state_nxt_s != RUN);
            ready           <= (state_nxt_s == RUN);
            fail            <= (state_nxt_s == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short phase lengths.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    int chk_cnt = 0;
    int pass_cnt = 0;

    pll_lock_sequencer #(
        .PLL_RESET_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .RETRY_W             (2)
    ) dut (
        .clock_in        (clk),
        .reset           (reset),
        .locked          (locked),
        .restart         (restart),
        .pll_resetb      (pll_resetb),
        .sys_reset       (sys_reset),
        .ready           (ready),
        .fail            (fail),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_pll_resetb"}, int'(pll_resetb), 0);
        check_val({tag, "_sys_reset"}, int'(sys_reset), 1);
        check_val({tag, "_ready"}, int'(ready), 0);
        check_val({tag, "_fail"}, int'(fail), 0);
        check_val({tag, "_retry"}, int'(retry_count), 0);
        check_val({tag, "_loss"}, int'(lock_loss_count), 0);
    endtask

    initial begin
        int rise_p;
        int rise_r;
        int early;
        int nrise;
        int rises [3];
        int fail_at;
        int ready_seen;
        logic prev_p;

        // Reset state
        locked = 1'b1;
        step(3);
        check_reset_vals("rst");

        // Nominal bring-up
        reset = 1'b0;
        rise_p = 0; rise_r = 0; early = 0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            if (pll_resetb && rise_p == 0) rise_p = k;
            if (ready && rise_r == 0) rise_r = k;
            if (!sys_reset && !ready) early++;
        end
        check_val("nom_pll_rise", rise_p, 4);
        check_val("nom_ready_at", rise_r, 13);
        check_val("nom_sys_reset", int'(sys_reset), 0);
        check_val("nom_retry", int'(retry_count), 0);
        check_val("nom_sysrst_early", early, 0);

        // Glitch at STABILIZE counter=5
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        rise_r = 0; early = 0;
        for (int k = 12; k <= 40; k++) begin
            step(1);
            if (ready && rise_r == 0) rise_r = k;
            if (!sys_reset && !ready) early++;
        end
        check_val("glitch_ready_at", rise_r, 22);
        check_val("glitch_sysrst_early", early, 0);
        check_val("glitch_retry", int'(retry_count), 0);

        // Lock loss in RUN
        locked = 1'b0;
        step(2);
        check_val("loss_ready_hold", int'(ready), 1);
        step(1);
        check_val("loss_ready", int'(ready), 0);
        check_val("loss_sys_reset", int'(sys_reset), 1);
        check_val("loss_count", int'(lock_loss_count), 1);
        check_val("loss_pll_resetb", int'(pll_resetb), 1);
        locked = 1'b1;
        step(10);
        check_val("relock_ready_early", int'(ready), 0);
        step(1);
        check_val("relock_ready", int'(ready), 1);
        check_val("relock_retry", int'(retry_count), 0);

        // No lock: retries then FAIL
        reset = 1'b1;
        locked = 1'b0;
        step(2);
        reset = 1'b0;
        nrise = 0; fail_at = 0; ready_seen = 0; prev_p = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            step(1);
            if (pll_resetb && !prev_p) begin
                if (nrise < 3) rises[nrise] = k;
                nrise++;
            end
            prev_p = pll_resetb;
            if (fail && fail_at == 0) fail_at = k;
            if (ready) ready_seen = 1;
        end
        check_val("nolock_pulses", nrise, 3);
        check_val("nolock_rise0", rises[0], 4);
        check_val("nolock_rise1", rises[1], 28);
        check_val("nolock_rise2", rises[2], 52);
        check_val("nolock_fail_at", fail_at, 72);
        check_val("nolock_retry", int'(retry_count), 2);
        check_val("nolock_pll_resetb", int'(pll_resetb), 0);
        check_val("nolock_ready_seen", ready_seen, 0);

        // Restart from FAIL
        locked = 1'b1;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check_val("rs_fail", int'(fail), 0);
        check_val("rs_retry", int'(retry_count), 0);
        check_val("rs_pll_resetb", int'(pll_resetb), 0);
        rise_p = 0; rise_r = 0;
        for (int k = 1; k <= 19; k++) begin
            step(1);
            if (pll_resetb && rise_p == 0) rise_p = k;
            if (ready && rise_r == 0) rise_r = k;
        end
        check_val("rs_pll_rise", rise_p, 4);
        check_val("rs_ready_at", rise_r, 13);

        // Accumulate five lock losses, then reset mid-STABILIZE with restart
        for (int n = 0; n < 4; n++) begin
            locked = 1'b0;
            step(3);
            locked = 1'b1;
            step(11);
        end
        check_val("multi_ready", int'(ready), 1);
        locked = 1'b0;
        step(3);
        check_val("multi_loss", int'(lock_loss_count), 5);
        locked = 1'b1;
        step(6);
        check_val("mid_stab_sys_reset", int'(sys_reset), 1);
        check_val("mid_stab_ready", int'(ready), 0);
        reset = 1'b1;
        restart = 1'b1;
        step(1);
        check_reset_vals("midrst");
        restart = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
